// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - fetch front end: two-entry line buffer, instruction extraction, line request FSM
// Straddling 32-bit instructions are assembled from the entries holding lines L and L+1.
module inst_fetch #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            flush,
  output logic [31:0]     inst,
  output logic            inst_valid,
  output logic            inst_comp,
  output logic            inst_fault,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  input  logic            resp_valid,
  input  logic [XLEN-1:0] resp_data,
  input  logic            resp_err
);

  localparam int TW = XLEN - 3;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]             state_q, state_d;
  logic                   drop_q, drop_d;
  logic                   req_valid_q, req_valid_d;
  logic [XLEN-1:0]        req_addr_q, req_addr_d;
  logic [1:0]             v_q, v_d;
  logic [1:0]             err_q, err_d;
  logic [1:0][TW-1:0]     tag_q, tag_d;
  logic [1:0][XLEN-1:0]   data_q, data_d;

  logic [TW-1:0]   line_l, line_n, need_line;
  logic            hit_l0, hit_l1, hit_n0, hit_n1, hit_l, hit_n;
  logic [XLEN-1:0] data_l, data_n, shifted;
  logic            err_l, err_n, comp, straddle, complete, err_inv;
  logic            need_valid, victim;
  logic [31:0]     raw;

  always_comb begin
    line_l   = pc[XLEN-1:3];
    line_n   = line_l + TW'(1);
    hit_l0   = v_q[0] && (tag_q[0] == line_l);
    hit_l1   = v_q[1] && (tag_q[1] == line_l);
    hit_n0   = v_q[0] && (tag_q[0] == line_n);
    hit_n1   = v_q[1] && (tag_q[1] == line_n);
    hit_l    = hit_l0 || hit_l1;
    hit_n    = hit_n0 || hit_n1;
    data_l   = hit_l0 ? data_q[0] : data_q[1];
    err_l    = hit_l0 ? err_q[0]  : err_q[1];
    data_n   = hit_n0 ? data_q[0] : data_q[1];
    err_n    = hit_n0 ? err_q[0]  : err_q[1];
    shifted  = data_l >> {pc[2:1], 4'b0000};
    comp     = shifted[1:0] != 2'b11;
    straddle = (pc[2:1] == 2'b11) && !comp;
    complete = hit_l && (!straddle || hit_n);
    err_inv  = err_l || (straddle && err_n);
    if (straddle)  raw = {data_n[15:0], shifted[15:0]};
    else if (comp) raw = {16'b0, shifted[15:0]};
    else           raw = shifted[31:0];
    inst_valid = !pc[0] && !flush && complete && !err_inv;
    inst_fault = pc[0] || (!flush && complete && err_inv);
    inst_comp  = inst_valid && comp;
    inst       = inst_valid ? raw : 32'b0;
    // A misaligned pc can never be fetched, so it must not trigger line traffic either.
    need_valid = !pc[0] && !(hit_l && hit_n);
    need_line  = hit_l ? line_n : line_l;
    victim     = hit_l0;
  end

  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    v_d         = v_q;
    err_d       = err_q;
    tag_d       = tag_q;
    data_d      = data_q;
    case (state_q)
      S_IDLE: begin
        if (need_valid && !flush) begin
          state_d     = S_REQ;
          req_valid_d = 1'b1;
          req_addr_d  = {need_line, 3'b000};
        end
      end
      S_REQ: begin
        if (flush) drop_d = 1'b1;
        if (req_ready) begin
          state_d     = S_WAIT;
          req_valid_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (resp_valid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (!drop_q && !flush) begin
            v_d[victim]    = 1'b1;
            err_d[victim]  = resp_err;
            tag_d[victim]  = req_addr_q[XLEN-1:3];
            data_d[victim] = resp_data;
          end
        end else if (flush) begin
          drop_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) v_d = 2'b00;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      drop_q      <= 1'b0;
      req_valid_q <= 1'b0;
      req_addr_q  <= {RESET_PC[XLEN-1:3], 3'b000};
      v_q         <= 2'b00;
      err_q       <= 2'b00;
      tag_q       <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      v_q         <= v_d;
      err_q       <= err_d;
      tag_q       <= tag_d;
      data_q      <= data_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = req_addr_q;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] pc = 64'h1000;
  logic        flush = 1'b0;
  logic [31:0] inst;
  logic        inst_valid, inst_comp, inst_fault, req_valid;
  logic [63:0] req_addr;
  logic        req_ready = 1'b0;
  logic        resp_valid = 1'b0;
  logic [63:0] resp_data = 64'h0;
  logic        resp_err = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;

  inst_fetch #(.XLEN(64), .RESET_PC(64'h1000)) dut (
    .clk(clk), .rst(rst), .pc(pc), .flush(flush),
    .inst(inst), .inst_valid(inst_valid), .inst_comp(inst_comp), .inst_fault(inst_fault),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output logic ok);
    for (int i = 0; i < 20 && !req_valid; i++) step();
    ok = req_valid;
  endtask

  task automatic serve(input logic [63:0] data, input logic err, output logic [63:0] addr, output logic ok);
    wait_req(ok);
    addr = req_addr;
    if (ok) begin
      req_ready = 1'b1; step(); req_ready = 1'b0;
      resp_valid = 1'b1; resp_data = data; resp_err = err; step();
      resp_valid = 1'b0; resp_err = 1'b0;
    end
  endtask

  task automatic do_flush(input logic [63:0] new_pc);
    pc = new_pc; flush = 1'b1; step(); flush = 1'b0;
  endtask

  task automatic test_reset();
    step(); step();
    total_cnt++; if (req_valid !== 1'b0) $display("FAIL rst_req_valid got %b exp 0", req_valid); else pass_cnt++;
    total_cnt++; if (req_addr !== 64'h1000) $display("FAIL rst_req_addr got %h exp 1000", req_addr); else pass_cnt++;
    total_cnt++; if ({inst_valid, inst_comp, inst_fault} !== 3'b000) $display("FAIL rst_flags got %b exp 000", {inst_valid, inst_comp, inst_fault}); else pass_cnt++;
    total_cnt++; if (inst !== 32'h0) $display("FAIL rst_inst got %h exp 0", inst); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_cold_start();
    logic [63:0] a; logic ok; logic seen;
    serve(64'h00000013_00000013, 1'b0, a, ok);
    total_cnt++; if (!ok || a !== 64'h1000) $display("FAIL cold_req got %h ok %b exp 1000", a, ok); else pass_cnt++;
    total_cnt++; if (inst !== 32'h13 || inst_valid !== 1'b1 || inst_comp !== 1'b0) $display("FAIL cold_inst got %h v %b c %b exp 00000013 1 0", inst, inst_valid, inst_comp); else pass_cnt++;
    serve(64'h0, 1'b0, a, ok);
    total_cnt++; if (!ok || a !== 64'h1008) $display("FAIL cold_prefetch got %h ok %b exp 1008", a, ok); else pass_cnt++;
    seen = 1'b0;
    repeat (3) begin step(); seen |= req_valid; end
    total_cnt++; if (seen !== 1'b0) $display("FAIL cold_idle got req %b exp 0", seen); else pass_cnt++;
  endtask

  task automatic test_compressed_straddle();
    logic [63:0] a; logic ok;
    pc = 64'h1000; flush = 1'b1; #1;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL flush_forces_invalid got %b exp 0", inst_valid); else pass_cnt++;
    step(); flush = 1'b0;
    serve(64'h0513_0000_4501_0001, 1'b0, a, ok);
    total_cnt++; if (!ok || a !== 64'h1000) $display("FAIL comp_req got %h ok %b exp 1000", a, ok); else pass_cnt++;
    total_cnt++; if (inst !== 32'h1 || inst_comp !== 1'b1 || inst_valid !== 1'b1) $display("FAIL comp_p0 got %h c %b v %b exp 00000001 1 1", inst, inst_comp, inst_valid); else pass_cnt++;
    pc = 64'h1002; #1;
    total_cnt++; if (inst !== 32'h4501 || inst_comp !== 1'b1 || inst_valid !== 1'b1) $display("FAIL comp_p1 got %h c %b v %b exp 00004501 1 1", inst, inst_comp, inst_valid); else pass_cnt++;
    pc = 64'h1006; #1;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL straddle_wait got %b exp 0", inst_valid); else pass_cnt++;
    serve(64'h0, 1'b0, a, ok);
    total_cnt++; if (!ok || a !== 64'h1008) $display("FAIL straddle_req got %h ok %b exp 1008", a, ok); else pass_cnt++;
    total_cnt++; if (inst !== 32'h513 || inst_valid !== 1'b1 || inst_comp !== 1'b0) $display("FAIL straddle_inst got %h v %b c %b exp 00000513 1 0", inst, inst_valid, inst_comp); else pass_cnt++;
  endtask

  task automatic test_flush_wait();
    logic [63:0] a; logic ok;
    do_flush(64'h1000);
    serve(64'h00000013_00000013, 1'b0, a, ok);
    wait_req(ok);
    total_cnt++; if (!ok || req_addr !== 64'h1008) $display("FAIL fw_prefetch got %h ok %b exp 1008", req_addr, ok); else pass_cnt++;
    req_ready = 1'b1; step(); req_ready = 1'b0;
    pc = 64'h2000; flush = 1'b1; step(); flush = 1'b0;
    resp_valid = 1'b1; resp_data = 64'h00000013_00000013; step(); resp_valid = 1'b0;
    pc = 64'h1008; #1;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL fw_dropped_written got %b exp 0", inst_valid); else pass_cnt++;
    pc = 64'h2000; #1;
    total_cnt++; if (inst_valid !== 1'b0) $display("FAIL fw_valid_early got %b exp 0", inst_valid); else pass_cnt++;
    serve(64'h00000013_00000013, 1'b0, a, ok);
    total_cnt++; if (!ok || a !== 64'h2000) $display("FAIL fw_redirect_req got %h ok %b exp 2000", a, ok); else pass_cnt++;
    total_cnt++; if (inst_valid !== 1'b1 || inst !== 32'h13) $display("FAIL fw_inst got %h v %b exp 00000013 1", inst, inst_valid); else pass_cnt++;
    serve(64'h0, 1'b0, a, ok);
    total_cnt++; if (!ok || a !== 64'h2008) $display("FAIL fw_prefetch2 got %h ok %b exp 2008", a, ok); else pass_cnt++;
  endtask

  task automatic test_bus_error();
    logic [63:0] a; logic ok; logic seen;
    do_flush(64'h3000);
    serve(64'h0, 1'b1, a, ok);
    total_cnt++; if (!ok || a !== 64'h3000) $display("FAIL err_req got %h ok %b exp 3000", a, ok); else pass_cnt++;
    total_cnt++; if (inst_fault !== 1'b1 || inst_valid !== 1'b0) $display("FAIL err_fault got f %b v %b exp 1 0", inst_fault, inst_valid); else pass_cnt++;
    serve(64'h0, 1'b0, a, ok);
    total_cnt++; if (!ok || a !== 64'h3008) $display("FAIL err_prefetch got %h ok %b exp 3008", a, ok); else pass_cnt++;
    pc = 64'h3001; flush = 1'b1; step(); flush = 1'b0;
    seen = 1'b0;
    repeat (5) begin step(); seen |= req_valid; end
    total_cnt++; if (seen !== 1'b0) $display("FAIL misalign_req got %b exp 0", seen); else pass_cnt++;
    total_cnt++; if (inst_fault !== 1'b1 || inst_valid !== 1'b0) $display("FAIL misalign_fault got f %b v %b exp 1 0", inst_fault, inst_valid); else pass_cnt++;
  endtask

  task automatic test_stall();
    logic ok; logic held;
    do_flush(64'h4000);
    wait_req(ok);
    total_cnt++; if (!ok) $display("FAIL stall_req got timeout exp req"); else pass_cnt++;
    held = 1'b1;
    repeat (5) begin
      if (req_valid !== 1'b1 || req_addr !== 64'h4000) held = 1'b0;
      step();
    end
    total_cnt++; if (held !== 1'b1) $display("FAIL stall_hold got %b exp 1 (addr %h)", held, req_addr); else pass_cnt++;
    req_ready = 1'b1; step(); req_ready = 1'b0;
    total_cnt++; if (req_valid !== 1'b0) $display("FAIL stall_single got %b exp 0", req_valid); else pass_cnt++;
    resp_valid = 1'b1; resp_data = 64'h0; step(); resp_valid = 1'b0;
    total_cnt++; if (inst_valid !== 1'b1 || inst !== 32'h0) $display("FAIL stall_inst got %h v %b exp 0 1", inst, inst_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] a; logic ok;
    wait_req(ok);
    req_ready = 1'b1; step(); req_ready = 1'b0;
    rst = 1'b1; #1;
    total_cnt++; if (req_valid !== 1'b0 || inst_valid !== 1'b0 || req_addr !== 64'h1000) $display("FAIL midrst got rv %b v %b a %h exp 0 0 1000", req_valid, inst_valid, req_addr); else pass_cnt++;
    step(); rst = 1'b0;
    serve(64'h0, 1'b0, a, ok);
    total_cnt++; if (!ok || a !== 64'h4000) $display("FAIL midrst_refetch got %h ok %b exp 4000", a, ok); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_cold_start();
    test_compressed_straddle();
    test_flush_wait();
    test_bus_error();
    test_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
endmodule
